seq_divider32: RTL and testbench

Iterative 32-bit radix-2 restoring divider, the inverse operation of the team's 32x32 Wallace-tree multiplier. It sits beside the multiplier in the ALU datapath. It produces a 32-bit quotient and remainder one bit per clock under a start/busy/done handshake. The block is fully synchronous apart from its asynchronous reset.

---
 rtl/seq_divider32.sv | 204 ++++++++++++++++++++
 tb/tb_seq_divider32.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_divider32
// Description : Iterative radix-2 restoring divider. Produces a WIDTH-bit
//               quotient and remainder, one quotient bit per clock, under a
//               start/busy/done handshake. Sits beside the Wallace-tree
//               multiplier in the ALU datapath.
//
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous, active-high reset
//               start      - request, sampled only while idle
//               dividend   - numerator, captured on the accepted start edge
//               divisor    - denominator, captured on the accepted start edge
//               busy       - high from accepted start until the done edge
//               done       - one-cycle pulse when results become valid
//               quotient   - result, held until the next completion
//               remainder  - result, held until the next completion
//               div_zero   - divisor was zero; valid with done, then held
//
// Options     : `define SIGNED_DIV_EN to treat operands as two's complement.
//               Magnitudes go through the unsigned core; the quotient is
//               negated when operand signs differ and the remainder takes the
//               dividend's sign. Corrections happen on the DONE edge, so the
//               latency is identical to the unsigned build.
//
// Latency     : 33 edges after the accepted start (1 edge for divide by 0).
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;          // captured divisor (magnitude)
  logic [WIDTH-1:0] quot_q, quot_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder
  logic             dz_q, dz_d;            // captured divide-by-zero flag
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] res_quot;
  logic [WIDTH-1:0] res_rem;

  // On divide by zero no iterations run, so quot_q still holds the captured
  // dividend (magnitude) and becomes the reported remainder.
  assign rem_src = dz_q ? quot_q : rem_q;

`ifdef SIGNED_DIV_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign res_quot = dz_q ? '1 : (neg_quot_q ? -quot_q : quot_q);
  // Re-applying the dividend sign restores the original dividend for /0.
  assign res_rem  = neg_rem_q ? -rem_src : rem_src;
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign res_quot = dz_q ? '1 : quot_q;
  assign res_rem  = rem_src;
`endif

  // 33-bit trial subtraction: the shifted partial remainder can exceed
  // WIDTH bits when the divisor is large, so the carry-in bit is kept.
  assign shifted_rem = {rem_q, quot_q[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef SIGNED_DIV_EN
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d   = dvs_mag;
          quot_d  = dvd_mag;
          rem_d   = '0;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          dz_d    = (divisor == '0);
          state_d = (divisor == '0) ? DONE : CALC;
`ifdef SIGNED_DIV_EN
          neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
`endif
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = shifted_rem[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        quotient_d  = res_quot;
        remainder_d = res_rem;
        div_zero_d  = dz_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      dvs_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef SIGNED_DIV_EN
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider32
// Description : Directed self-checking bench for seq_divider32. Each scenario
//               task drives its own stimulus and checks results inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Issue one division and wait (bounded) for done. lat = edges from the
  // accepted start edge to the edge after which done is seen; busy_cyc =
  // number of sampled cycles with busy high before done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat, output int busy_cyc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;          // must not disturb the operation in flight
    divisor  = b + 32'd1;
    lat      = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (quotient !== 32'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] q, r;
    logic        dz;
    int          lat, bc;
    run_div(32'd100, 32'd7, q, r, dz, lat, bc);
    total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_quot got=%0d exp=14", q); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL basic_rem got=%0d exp=2", r); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL basic_dz got=%b exp=0", dz); end
    total++; if (lat != 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    total++; if (bc != 33) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=33", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL basic_quot_hold got=%0d exp=14", quotient); end
  endtask

  task automatic test_unsigned_edges();
    logic [31:0] q, r;
    logic        dz;
    int          lat, bc;
    run_div(32'hFFFF_FFFF, 32'd1, q, r, dz, lat, bc);
    total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL max_div1_quot got=%h exp=ffffffff", q); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL max_div1_rem got=%h exp=0", r); end
    run_div(32'd5, 32'd10, q, r, dz, lat, bc);
    total++; if (q !== 32'd0) begin bad++; $display("FAIL small_quot got=%0d exp=0", q); end
    total++; if (r !== 32'd5) begin bad++; $display("FAIL small_rem got=%0d exp=5", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic        dz;
    int          lat, bc;
    run_div(32'h1234_5678, 32'd0, q, r, dz, lat, bc);
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    total++; if (bc != 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot got=%h exp=ffffffff", q); end
    total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL dz_rem got=%h exp=12345678", r); end
    run_div(32'd10, 32'd3, q, r, dz, lat, bc);
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL dz_clear got=%b exp=0", dz); end
    total++; if (q !== 32'd3 || r !== 32'd1) begin bad++; $display("FAIL after_dz got=%0d/%0d exp=3/1", q, r); end
  endtask

  task automatic test_ignore_and_abort();
    int c0, w;
    bit seen;
    // Run 1: a start pulse while busy must be ignored.
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd5; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    total++; if (cyc - c0 != 33) begin bad++; $display("FAIL ignore_latency got=%0d exp=33", cyc - c0); end
    total++; if (quotient !== 32'd333 || remainder !== 32'd1) begin
      bad++; $display("FAIL ignore_result got=%0d/%0d exp=333/1", quotient, remainder); end
    repeat (2) @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%b exp=0", busy); end

    // Run 2: reset mid-operation aborts with no done pulse.
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++; $display("FAIL abort_results got=%h/%h exp=0/0", quotient, remainder); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL abort_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_signed_cfg();
    logic [31:0] q, r;
    logic        dz;
    int          lat, bc;
    run_div(32'hFFFF_FFF9, 32'd2, q, r, dz, lat, bc);
`ifdef SIGNED_DIV_EN
    total++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL neg7_div2 got=%h/%h exp=fffffffd/ffffffff", q, r); end
`else
    total++; if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
      bad++; $display("FAIL big_div2 got=%h/%h exp=7ffffffc/00000001", q, r); end
`endif
    total++; if (lat != 33) begin bad++; $display("FAIL cfg_latency got=%0d exp=33", lat); end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, lat, bc);
`ifdef SIGNED_DIV_EN
    total++; if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      bad++; $display("FAIL min_div_m1 got=%h/%h/%b exp=80000000/00000000/0", q, r, dz); end
`else
    total++; if (q !== 32'd0 || r !== 32'h8000_0000 || dz !== 1'b0) begin
      bad++; $display("FAIL half_div_max got=%h/%h/%b exp=00000000/80000000/0", q, r, dz); end
`endif
    run_div(32'd7, 32'hFFFF_FFFE, q, r, dz, lat, bc);
`ifdef SIGNED_DIV_EN
    total++; if (q !== 32'hFFFF_FFFD || r !== 32'd1) begin
      bad++; $display("FAIL 7_div_m2 got=%h/%h exp=fffffffd/00000001", q, r); end
`else
    total++; if (q !== 32'd0 || r !== 32'd7) begin
      bad++; $display("FAIL 7_div_big got=%h/%h exp=00000000/00000007", q, r); end
`endif
    run_div(32'hFFFF_FFF9, 32'd0, q, r, dz, lat, bc);
    total++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF9 || dz !== 1'b1) begin
      bad++; $display("FAIL neg_dz got=%h/%h/%b exp=ffffffff/fffffff9/1", q, r, dz); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [6];
    logic [31:0] dv [6];
    logic [63:0] recon;
    int          w, dc, prev;
    for (int i = 0; i < 6; i++) begin
      av[i] = $urandom;
      dv[i] = $urandom >> $urandom_range(0, 31);
`ifdef SIGNED_DIV_EN
      av[i][31] = 1'b0;
      dv[i][31] = 1'b0;
`endif
      if (dv[i] == 32'd0) dv[i] = 32'd1;
    end
    av[0] = 32'd123456789;   // fixed first pair keeps one vector hand-checkable
    dv[0] = 32'd1000;        // 123456789 / 1000 = 123456 rem 789
    @(negedge clk);
    dividend = av[0]; divisor = dv[0]; start = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      do begin @(posedge clk); #1; w++; end while (done !== 1'b1 && w < 100);
      dc = cyc;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_timeout[%0d] got=no_done exp=done", k); end
      if (k == 0) begin
        total++; if (quotient !== 32'd123456 || remainder !== 32'd789) begin
          bad++; $display("FAIL b2b_fixed got=%0d/%0d exp=123456/789", quotient, remainder); end
      end
      recon = 64'(quotient) * 64'(dv[k]) + 64'(remainder);
      total++; if (recon !== 64'(av[k])) begin
        bad++; $display("FAIL b2b_identity[%0d] got=%h exp=%h", k, recon, av[k]); end
      total++; if (!(remainder < dv[k])) begin
        bad++; $display("FAIL b2b_rem_bound[%0d] got=%h exp=<%h", k, remainder, dv[k]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_done[%0d] got=%b exp=0", k, busy); end
      if (k > 0) begin
        total++; if (dc - prev != 34) begin
          bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=34", k, dc - prev); end
      end
      prev = dc;
      if (k < 5) begin
        dividend = av[k+1];
        divisor  = dv[k+1];
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned_edges();
    test_div_zero();
    test_ignore_and_abort();
    test_signed_cfg();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
